// File: rtl/ysyx_24100013_ifu_pkg.sv
// Shared types and constants for the ysyx_24100013 instruction fetch unit.
// Imported by the IFU top, its PC sub-module and the IFU interface.
package ysyx_24100013_pkg;

    localparam int unsigned INST_W = 32;
    localparam logic [31:0] PC_INC = 32'd4;

    localparam logic [31:0] DEF_RESET_PC   = 32'h8000_0000;
    localparam logic [31:0] DEF_PMEM_BASE  = 32'h8000_0000;
    localparam logic [31:0] DEF_PMEM_LIMIT = 32'h8800_0000;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } ifu_state_t;

    function automatic logic pc_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

    function automatic logic pc_outside(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] limit);
        return (addr < base) || (addr >= limit);
    endfunction

endpackage

// File: rtl/ysyx_24100013_ifu_if.sv
// Bundle of the IFU's redirect, instruction-memory and decode channels.
// master = IFU side, slave = memory/decode/execute side.
interface ysyx_24100013_ifu_if;
    import ysyx_24100013_pkg::*;

    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [31:0]       imem_req_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;
    logic              imem_rsp_ready;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst;
    logic [31:0]       inst_pc;
    logic              fault;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output imem_rsp_ready,
        output inst_valid, inst, inst_pc,
        input  inst_ready,
        output fault
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  imem_rsp_ready,
        input  inst_valid, inst, inst_pc,
        output inst_ready,
        input  fault
    );

endinterface

// File: rtl/ysyx_24100013_ifu_pc.sv
// Architectural PC register with next-PC selection and fetch-fault detection.
// Range checking is compiled in by YSYX_24100013_IFU_RANGE_CHECK_EN.
module ysyx_24100013_ifu_pc
    import ysyx_24100013_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] PMEM_BASE  = DEF_PMEM_BASE,
    parameter logic [31:0] PMEM_LIMIT = DEF_PMEM_LIMIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        advance,
    output logic [31:0] pc,
    output logic        load_fault,
    output logic        pc_fault
);

`ifdef YSYX_24100013_IFU_RANGE_CHECK_EN
    localparam logic RANGE_EN = 1'b1;
`else
    localparam logic RANGE_EN = 1'b0;
`endif

    logic [31:0] next_pc;
    logic        load;

    // Redirect has priority over the sequential step.
    always_comb begin
        next_pc = pc;
        load    = 1'b0;
        if (redirect_en) begin
            next_pc = redirect_pc;
            load    = 1'b1;
        end else if (advance) begin
            next_pc = pc + PC_INC;
            load    = 1'b1;
        end
    end

    assign load_fault = (redirect_en && pc_misaligned(redirect_pc[1:0]))
                      || (RANGE_EN && load && pc_outside(next_pc, PMEM_BASE, PMEM_LIMIT));

    // Covers the reset PC, which is never loaded through next_pc.
    assign pc_fault = RANGE_EN && pc_outside(pc, PMEM_BASE, PMEM_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

endmodule

// File: rtl/ysyx_24100013_ifu.sv
// Instruction fetch unit: owns the PC, fetches words from imem, hands them to decode.
// Optional range check: define YSYX_24100013_IFU_RANGE_CHECK_EN.
module ysyx_24100013_ifu
    import ysyx_24100013_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] PMEM_BASE  = DEF_PMEM_BASE,
    parameter logic [31:0] PMEM_LIMIT = DEF_PMEM_LIMIT
) (
    input  logic               clk,
    input  logic               rst,
    ysyx_24100013_ifu_if.master bus
);

    ifu_state_t        state;
    logic              kill;
    logic              req_valid;
    logic              rsp_ready;
    logic              inst_valid;
    logic              fault;
    logic [INST_W-1:0] inst;
    logic [31:0]       inst_pc;
    logic [31:0]       pc;

    logic redir;
    logic req_fire;
    logic rsp_fire;
    logic inst_fire;
    logic load_fault;
    logic pc_fault;
    logic go_fault;

    assign redir     = bus.redirect_valid && (state != S_FAULT);
    assign req_fire  = req_valid && bus.imem_req_ready;
    assign rsp_fire  = rsp_ready && bus.imem_rsp_valid;
    assign inst_fire = inst_valid && bus.inst_ready;

    ysyx_24100013_ifu_pc #(
        .RESET_PC   (RESET_PC),
        .PMEM_BASE  (PMEM_BASE),
        .PMEM_LIMIT (PMEM_LIMIT)
    ) u_pc (
        .clk         (clk),
        .rst         (rst),
        .redirect_en (redir),
        .redirect_pc (bus.redirect_pc),
        .advance     (inst_fire),
        .pc          (pc),
        .load_fault  (load_fault),
        .pc_fault    (pc_fault)
    );

    // REQ with req_valid low is the first cycle after reset: the reset PC is vetted there.
    assign go_fault = load_fault
                    || ((state == S_REQ) && !req_valid && !redir && pc_fault);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_REQ;
            kill       <= 1'b0;
            req_valid  <= 1'b0;
            rsp_ready  <= 1'b0;
            inst_valid <= 1'b0;
            fault      <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
        end else if (go_fault) begin
            state      <= S_FAULT;
            fault      <= 1'b1;
            kill       <= 1'b0;
            req_valid  <= 1'b0;
            rsp_ready  <= 1'b0;
            inst_valid <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (req_fire) begin
                        state     <= S_WAIT;
                        req_valid <= 1'b0;
                        rsp_ready <= 1'b1;
                        kill      <= redir;
                    end else begin
                        req_valid <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (rsp_fire) begin
                        rsp_ready <= 1'b0;
                        kill      <= 1'b0;
                        if (kill || redir) begin
                            state     <= S_REQ;
                            req_valid <= 1'b1;
                        end else begin
                            state      <= S_HOLD;
                            inst_valid <= 1'b1;
                            inst       <= bus.imem_rsp_data;
                            inst_pc    <= pc;
                        end
                    end else if (redir) begin
                        kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redir || inst_fire) begin
                        state      <= S_REQ;
                        inst_valid <= 1'b0;
                        req_valid  <= 1'b1;
                    end
                end
                S_FAULT: begin
                end
                default: begin
                    state <= S_FAULT;
                end
            endcase
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc;
    assign bus.imem_rsp_ready = rsp_ready;
    assign bus.inst_valid     = inst_valid;
    assign bus.inst           = inst;
    assign bus.inst_pc        = inst_pc;
    assign bus.fault          = fault;

endmodule

// File: tb/tb_ysyx_24100013_ifu.sv
// Self-checking bench for ysyx_24100013_ifu: memory model, program-order reference
// of expected fetch/consume PCs, directed scenarios and a randomized run.
module tb_ysyx_24100013_ifu;
    import ysyx_24100013_pkg::*;

    localparam logic [31:0] T_RESET = 32'h8000_0000;
    localparam logic [31:0] T_LIMIT = 32'h8800_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_24100013_ifu_if bus();

    ysyx_24100013_ifu #(
        .RESET_PC   (T_RESET),
        .PMEM_BASE  (32'h8000_0000),
        .PMEM_LIMIT (T_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned total;
    int unsigned bad;
    int unsigned cyc;

    logic        mem_busy;
    int unsigned mem_cnt;
    int unsigned mem_lat;
    int unsigned stall_left;
    int unsigned ready_pct;
    logic [31:0] mem_addr;
    logic        ovr_en;
    logic [31:0] ovr_addr;
    logic [31:0] ovr_data;

    logic        ev_acc, ev_take, ev_cons, ev_redir;
    logic [31:0] ev_acc_addr, ev_cons_pc, ev_cons_inst, ev_redir_pc;
    logic        seen_dead;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (ovr_en && a == ovr_addr) return ovr_data;
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_0F0F;
    endfunction

    // One clock: record handshakes just before the edge, then advance the memory model.
    task automatic step();
        @(negedge clk);
        ev_acc       = bus.imem_req_valid && bus.imem_req_ready;
        ev_acc_addr  = bus.imem_req_addr;
        ev_take      = bus.imem_rsp_valid && bus.imem_rsp_ready;
        ev_cons      = bus.inst_valid && bus.inst_ready;
        ev_cons_pc   = bus.inst_pc;
        ev_cons_inst = bus.inst;
        ev_redir     = bus.redirect_valid;
        ev_redir_pc  = bus.redirect_pc;
        if (bus.inst_valid && bus.inst == 32'hDEAD_BEEF) seen_dead = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            mem_busy = 1'b0;
        end else begin
            if (ev_take) mem_busy = 1'b0;
            if (ev_acc) begin
                mem_busy = 1'b1;
                mem_cnt  = mem_lat;
                mem_addr = ev_acc_addr;
            end else if (mem_busy && mem_cnt > 0) begin
                mem_cnt--;
            end
        end
        if (stall_left > 0) stall_left--;
        bus.imem_rsp_valid = mem_busy && (mem_cnt == 0);
        bus.imem_rsp_data  = mem_busy ? mem_word(mem_addr) : 32'h0;
        bus.imem_req_ready = (stall_left == 0) && ($urandom_range(99) < ready_pct);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.inst_ready     = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.imem_req_ready = 1'b1;
        mem_busy = 1'b0; mem_cnt = 0; mem_lat = 0; stall_left = 0; ready_pct = 100;
        ovr_en = 1'b0; seen_dead = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic got;
        do_reset();
        for (int n = 0; n < 20 && !bus.inst_valid; n++) step();
        total++;
        if (bus.inst_valid !== 1'b1) begin bad++; $display("FAIL reset_prefill: inst_valid=%b want 1", bus.inst_valid); end
        rst = 1'b1;
        step();
        total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid); end
        total++; if (bus.imem_rsp_ready !== 1'b0) begin bad++; $display("FAIL reset_rsp_ready: got %b want 0", bus.imem_rsp_ready); end
        total++; if (bus.inst_valid !== 1'b0) begin bad++; $display("FAIL reset_inst_valid: got %b want 0", bus.inst_valid); end
        total++; if (bus.inst !== 32'h0) begin bad++; $display("FAIL reset_inst: got %h want 0", bus.inst); end
        total++; if (bus.inst_pc !== 32'h0) begin bad++; $display("FAIL reset_inst_pc: got %h want 0", bus.inst_pc); end
        total++; if (bus.fault !== 1'b0) begin bad++; $display("FAIL reset_fault: got %b want 0", bus.fault); end
        rst = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            step();
            if (ev_acc) begin
                got = 1'b1;
                total++;
                if (ev_acc_addr !== T_RESET) begin bad++; $display("FAIL reset_first_addr: got %h want %h", ev_acc_addr, T_RESET); end
            end
        end
        total++; if (!got) begin bad++; $display("FAIL reset_first_req: no request within budget"); end
    endtask

    task automatic test_stream();
        int unsigned ncons, nacc, last_cyc;
        ncons = 0; nacc = 0; last_cyc = 0;
        do_reset();
        bus.inst_ready = 1'b1;
        for (int n = 0; n < 60 && ncons < 4; n++) begin
            step();
            if (ev_acc) begin
                total++;
                if (ev_acc_addr !== T_RESET + 32'(4 * nacc)) begin bad++; $display("FAIL stream_addr: got %h want %h", ev_acc_addr, T_RESET + 32'(4 * nacc)); end
                nacc++;
            end
            if (ev_cons) begin
                total++;
                if (ev_cons_pc !== T_RESET + 32'(4 * ncons) || ev_cons_inst !== mem_word(T_RESET + 32'(4 * ncons))) begin
                    bad++; $display("FAIL stream_inst: got pc=%h inst=%h want pc=%h inst=%h", ev_cons_pc, ev_cons_inst,
                                    T_RESET + 32'(4 * ncons), mem_word(T_RESET + 32'(4 * ncons)));
                end
                if (ncons > 0) begin
                    total++;
                    if (cyc - last_cyc !== 3) begin bad++; $display("FAIL stream_gap: got %0d cycles want 3", cyc - last_cyc); end
                end
                last_cyc = cyc;
                ncons++;
            end
        end
        total++; if (ncons != 4) begin bad++; $display("FAIL stream_count: got %0d want 4", ncons); end
    endtask

    task automatic test_req_stall();
        int unsigned nacc;
        do_reset();
        for (int n = 0; n < 10 && !bus.imem_req_valid; n++) step();
        total++; if (bus.imem_req_valid !== 1'b1) begin bad++; $display("FAIL stall_start: req_valid=%b want 1", bus.imem_req_valid); end
        stall_left = 4;
        bus.imem_req_ready = 1'b0;
        nacc = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            total++; if (ev_acc) begin bad++; $display("FAIL stall_accept: accepted during stall cycle %0d", k); end
            total++;
            if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== T_RESET) begin
                bad++; $display("FAIL stall_hold: got valid=%b addr=%h want 1 %h", bus.imem_req_valid, bus.imem_req_addr, T_RESET);
            end
        end
        for (int k = 0; k < 10; k++) begin
            step();
            if (ev_acc) nacc++;
        end
        total++; if (nacc != 1) begin bad++; $display("FAIL stall_count: got %0d accepts want 1", nacc); end
        total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== T_RESET) begin
            bad++; $display("FAIL stall_inst: got valid=%b pc=%h want 1 %h", bus.inst_valid, bus.inst_pc, T_RESET);
        end
    endtask

    task automatic test_redirect_wait();
        logic got_acc, got_cons, first;
        do_reset();
        bus.inst_ready = 1'b1;
        mem_lat = 2;
        ovr_en = 1'b1; ovr_addr = T_RESET; ovr_data = 32'hDEAD_BEEF;
        got_acc = 1'b0;
        for (int n = 0; n < 10 && !got_acc; n++) begin
            step();
            got_acc = ev_acc;
        end
        total++; if (!got_acc || ev_acc_addr !== T_RESET) begin bad++; $display("FAIL rw_first: got acc=%b addr=%h want 1 %h", got_acc, ev_acc_addr, T_RESET); end
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_0100;
        step();
        bus.redirect_valid = 1'b0;
        first = 1'b1; got_cons = 1'b0;
        for (int n = 0; n < 30 && !got_cons; n++) begin
            step();
            if (ev_acc && first) begin
                first = 1'b0;
                total++; if (ev_acc_addr !== 32'h8000_0100) begin bad++; $display("FAIL rw_next_addr: got %h want 80000100", ev_acc_addr); end
            end
            if (ev_cons) begin
                got_cons = 1'b1;
                total++;
                if (ev_cons_pc !== 32'h8000_0100 || ev_cons_inst !== mem_word(32'h8000_0100)) begin
                    bad++; $display("FAIL rw_inst: got pc=%h inst=%h want pc=80000100 inst=%h", ev_cons_pc, ev_cons_inst, mem_word(32'h8000_0100));
                end
            end
        end
        total++; if (!got_cons) begin bad++; $display("FAIL rw_progress: no instruction after redirect"); end
        total++; if (seen_dead) begin bad++; $display("FAIL rw_killed: got inst deadbeef want never"); end
    endtask

    task automatic test_hold_redirect();
        int unsigned old_cons;
        logic first_acc, first_cons;
        do_reset();
        for (int n = 0; n < 20 && !bus.inst_valid; n++) step();
        bus.inst_ready = 1'b1;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_0040;
        step();
        bus.redirect_valid = 1'b0;
        total++; if (!ev_cons || ev_cons_pc !== T_RESET) begin bad++; $display("FAIL hr_consume: got cons=%b pc=%h want 1 %h", ev_cons, ev_cons_pc, T_RESET); end
        total++; if (bus.inst_valid !== 1'b0) begin bad++; $display("FAIL hr_drop: inst_valid=%b want 0", bus.inst_valid); end
        old_cons = 0; first_acc = 1'b1; first_cons = 1'b1;
        for (int n = 0; n < 20; n++) begin
            step();
            if (ev_cons && ev_cons_pc == T_RESET) old_cons++;
            if (ev_acc && first_acc) begin
                first_acc = 1'b0;
                total++; if (ev_acc_addr !== 32'h8000_0040) begin bad++; $display("FAIL hr_next_addr: got %h want 80000040", ev_acc_addr); end
            end
            if (ev_cons && first_cons) begin
                first_cons = 1'b0;
                total++; if (ev_cons_pc !== 32'h8000_0040) begin bad++; $display("FAIL hr_next_pc: got %h want 80000040", ev_cons_pc); end
            end
        end
        total++; if (old_cons != 0) begin bad++; $display("FAIL hr_once: got %0d extra consumes want 0", old_cons); end
        total++; if (first_acc) begin bad++; $display("FAIL hr_progress: no request after redirect"); end
    endtask

    task automatic test_misalign();
        int unsigned nreq;
        logic got;
        do_reset();
        bus.inst_ready = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin step(); got = ev_acc; end
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_0102;
        step();
        bus.redirect_valid = 1'b0;
        total++; if (bus.fault !== 1'b1) begin bad++; $display("FAIL mis_fault: got %b want 1", bus.fault); end
        total++; if (bus.imem_req_valid !== 1'b0 || bus.imem_rsp_ready !== 1'b0 || bus.inst_valid !== 1'b0) begin
            bad++; $display("FAIL mis_quiet: got req=%b rsp_rdy=%b inst_v=%b want 0 0 0", bus.imem_req_valid, bus.imem_rsp_ready, bus.inst_valid);
        end
        nreq = 0;
        for (int n = 0; n < 20; n++) begin
            bus.redirect_valid = n[0];
            bus.redirect_pc    = T_RESET + 32'(n * 8);
            step();
            if (bus.imem_req_valid || ev_acc || !bus.fault) nreq++;
        end
        bus.redirect_valid = 1'b0;
        total++; if (nreq != 0) begin bad++; $display("FAIL mis_sticky: got %0d bad cycles want 0", nreq); end
        rst = 1'b1;
        step();
        total++; if (bus.fault !== 1'b0) begin bad++; $display("FAIL mis_clear: got %b want 0", bus.fault); end
        rst = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin step(); got = ev_acc; end
        total++; if (!got || ev_acc_addr !== T_RESET) begin bad++; $display("FAIL mis_restart: got acc=%b addr=%h want 1 %h", got, ev_acc_addr, T_RESET); end
    endtask

    task automatic test_range();
        logic got;
        do_reset();
        for (int n = 0; n < 20 && !bus.inst_valid; n++) step();
        bus.redirect_valid = 1'b1; bus.redirect_pc = T_LIMIT;
        step();
        bus.redirect_valid = 1'b0;
        got = 1'b0;
`ifdef YSYX_24100013_IFU_RANGE_CHECK_EN
        total++; if (bus.fault !== 1'b1) begin bad++; $display("FAIL range_fault: got %b want 1", bus.fault); end
        for (int n = 0; n < 10; n++) begin step(); if (ev_acc || bus.imem_req_valid) got = 1'b1; end
        total++; if (got) begin bad++; $display("FAIL range_noreq: request issued want none"); end
`else
        total++; if (bus.fault !== 1'b0) begin bad++; $display("FAIL range_fault: got %b want 0", bus.fault); end
        for (int n = 0; n < 10 && !got; n++) begin step(); got = ev_acc; end
        total++; if (!got || ev_acc_addr !== T_LIMIT) begin bad++; $display("FAIL range_req: got acc=%b addr=%h want 1 %h", got, ev_acc_addr, T_LIMIT); end
`endif
    endtask

    // Reference: consumed PCs follow program order; a redirect restarts it at the target.
    task automatic test_random();
        logic [31:0] exp_pc;
        int unsigned ncons;
        logic fault_seen;
        do_reset();
        ready_pct = 70;
        exp_pc = T_RESET; ncons = 0; fault_seen = 1'b0;
        for (int n = 0; n < 800; n++) begin
            mem_lat = $urandom_range(3, 0);
            bus.inst_ready = ($urandom_range(3, 0) != 0);
            bus.redirect_valid = ($urandom_range(11, 0) == 0);
            bus.redirect_pc = T_RESET + ($urandom_range(255, 0) << 2);
            step();
            if (ev_acc) begin
                total++;
                if (ev_acc_addr !== exp_pc) begin bad++; $display("FAIL rand_addr: got %h want %h at cycle %0d", ev_acc_addr, exp_pc, cyc); end
            end
            if (ev_cons) begin
                total++;
                if (ev_cons_pc !== exp_pc || ev_cons_inst !== mem_word(exp_pc)) begin
                    bad++; $display("FAIL rand_inst: got pc=%h inst=%h want pc=%h inst=%h", ev_cons_pc, ev_cons_inst, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                ncons++;
            end
            if (ev_redir) exp_pc = ev_redir_pc;
            if (bus.fault) fault_seen = 1'b1;
        end
        bus.redirect_valid = 1'b0;
        total++; if (ncons < 40) begin bad++; $display("FAIL rand_progress: got %0d instructions want >= 40", ncons); end
        total++; if (fault_seen) begin bad++; $display("FAIL rand_fault: got fault=1 want 0"); end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        rst = 1'b1;
        bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.inst_ready = 1'b0;
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0;
        test_reset();
        test_stream();
        test_req_stall();
        test_redirect_wait();
        test_hold_redirect();
        test_misalign();
        test_range();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ysyx_24100013_ifu.md
Name: ysyx_24100013_ifu

Overview:
- Instruction fetch unit: owns the architectural PC and issues word reads to instruction memory over a valid/ready request and response channel.
- Hands fetched instructions, with their PCs, to decode/execute over a valid/ready channel.
- Consumes the execute stage's next-PC redirect (jal/jalr target) and is the only place the PC is advanced.
- Replaces the ad-hoc pc/dnpc registers currently held in the execute unit.

Parameters:
- RESET_PC, 32'h80000000, first fetch address after reset.
- PMEM_BASE, 32'h80000000, lowest legal fetch address (used by the range check).
- PMEM_LIMIT, 32'h88000000, first illegal address above memory (exclusive bound).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- redirect_valid  in  1  execute reports a taken jump this cycle.
- redirect_pc  in  32  jump target.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  word address of the request.
- imem_rsp_valid  in  1  read data valid.
- imem_rsp_data  in  32  instruction word.
- imem_rsp_ready  out  1  IFU accepts the response.
- inst_valid  out  1  inst/inst_pc valid for decode.
- inst_ready  in  1  decode consumes the instruction.
- inst  out  32  instruction word.
- inst_pc  out  32  address of inst.
- fault  out  1  sticky fetch fault.

Behaviour:
- Reset (clk edge with rst=1): pc=RESET_PC; state=REQ; kill=0.
  - All handshake outputs are 0 and fault=0.
  - inst and inst_pc are 0.
  - Reset mid-transaction abandons any outstanding request or response; the memory side must reset together with the IFU.
- FSM states: REQ, WAIT, HOLD, FAULT.
- REQ:
  - imem_req_valid=1 and imem_req_addr=pc.
  - On imem_req_ready: go to WAIT.
  - Memory samples the address only on the handshake cycle, so the address may change while unaccepted.
- WAIT:
  - imem_rsp_ready=1.
  - On imem_rsp_valid with kill=0: capture data into inst and pc into inst_pc, go to HOLD.
  - On imem_rsp_valid with kill=1: discard the data, clear kill, go to REQ.
- HOLD:
  - inst_valid=1; inst and inst_pc stay stable until consumed.
  - On inst_ready: pc=pc+4 (mod 2^32), go to REQ.
- Latency: minimum 3 cycles per instruction (REQ, WAIT, HOLD), with zero-wait memory and inst_ready held high.
- Redirect, accepted in every state except FAULT; pc=redirect_pc next cycle.
  - REQ, no handshake this cycle: the next cycle requests redirect_pc.
  - REQ, handshake this cycle: set kill, go to WAIT.
  - WAIT: set kill; the in-flight response is dropped.
  - HOLD: inst_valid deasserts next cycle, go to REQ. Redirect together with inst_ready means the instruction is consumed and the redirect wins over pc+4.
  - WAIT, response and redirect in the same cycle: the response is dropped, go to REQ at redirect_pc.
- Misaligned redirect (redirect_pc[1:0]!=0):
  - fault=1 next cycle, state=FAULT, pc=redirect_pc.
  - FAULT is left only by rst. All valid/ready outputs are 0 in FAULT.
- The PC wraps from 32'hFFFFFFFC to 0 with no special handling unless the range check is compiled in.

Optional Feature:
- Macro: YSYX_24100013_IFU_RANGE_CHECK_EN.
- Defined: any pc about to enter REQ with pc<PMEM_BASE or pc>=PMEM_LIMIT raises fault and enters FAULT. This covers reset, sequential and redirect PCs. No request is issued for that address.
- Undefined: no range check; only the misalignment fault exists.

Decomposition:
- Package ysyx_24100013_pkg holds:
  - the IFU state enum (REQ, WAIT, HOLD, FAULT);
  - RESET_PC, PMEM_BASE and PMEM_LIMIT defaults;
  - INST_W=32 and the PC increment constant 4.
- Sub-module ysyx_24100013_ifu_pc: pc register, next-PC selection (redirect, pc+4, hold) and fault detection. The top level keeps the FSM, kill flag and the output registers.

Test Plan:
- Reset, zero-wait memory, inst_ready=1 -> requests to 0x80000000, 0x80000004, 0x80000008, each instruction out 3 cycles apart; inst_pc matches each address.
- Memory holds imem_req_ready=0 for 4 cycles -> imem_req_valid and imem_req_addr=0x80000000 stay asserted; exactly one request is accepted.
- Redirect to 0x80000100 during WAIT (response 0xDEADBEEF arrives 2 cycles later) -> 0xDEADBEEF never appears on inst; next request is 0x80000100.
- HOLD with inst_ready=1 and redirect to 0x80000040 in the same cycle -> the instruction counts once; next request is 0x80000040, not pc+4.
- Redirect to 0x80000102 -> fault=1 next cycle; no further imem_req_valid until rst; rst clears fault and fetch restarts at 0x80000000.
- With YSYX_24100013_IFU_RANGE_CHECK_EN: redirect to 0x88000000 -> fault with no request issued. Without the macro: a request to 0x88000000 is issued.
